// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-file bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    WR_COMMIT,
    RD_FETCH,
    RD
  } state_e;

  localparam int CMD_RW_BIT          = 7;
  localparam int CMD_AUTOINC_BIT     = 6;
  localparam int CMD_ADDR_MSB        = 5;
  localparam int CMD_ADDR_LSB        = 0;
  localparam int ADDRESS_MAX_DEFAULT = 48;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  // [1:0] is the synchroniser, [2] holds the previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync_q <= {3{RESET_VAL}};
    else         sync_q <= {sync_q[1:0], i_async};
  end

  assign o_sync = sync_q[1];
  assign o_rise = sync_q[1] & ~sync_q[2];
  assign o_fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 target that issues single-cycle read/write strobes on the register-file bus.
//
// state     | meaning
// IDLE      | no frame; wait for CS fall
// CMD       | shifting command byte (RW, AUTO_INC, start address)
// WR        | shifting a write data byte
// WR_COMMIT | one cycle: drive io_data and pulse write strobe
// RD_FETCH  | one cycle: pulse read strobe, capture io_data into TX
// RD        | shifting TX out on MISO, MOSI ignored
module spi_register_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int ADDRESS_MAX   = ADDRESS_MAX_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_spi_sck,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_mosi,
  output logic                     o_spi_miso,
  output logic                     o_write_en,
  output logic                     o_read_en,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  inout  wire  [7:0]               io_data,
  output logic                     o_busy
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX_L = ADDRESS_WIDTH'(ADDRESS_MAX);

  logic sck_rise, sck_fall, unused_sck_s;
  logic cs_n_s, cs_fall, unused_cs_rise;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_spi_sck),
    .o_sync(unused_sck_s), .o_rise(sck_rise), .o_fall(sck_fall));

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_spi_cs_n),
    .o_sync(cs_n_s), .o_rise(unused_cs_rise), .o_fall(cs_fall));

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_spi_mosi),
    .o_sync(mosi_s), .o_rise(unused_mosi_rise), .o_fall(unused_mosi_fall));

  logic [2:0]               bit_cnt_q;
  logic [6:0]               rx_q;
  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     autoinc_q;
  logic [7:0]               wdata_q, tx_q;
  logic                     miso_q, wr_en_q, rd_en_q, oe_q, busy_q;

  logic                     byte_done;
  logic [7:0]               rx_byte, rd_byte;
  logic                     mapped;
  logic [ADDRESS_WIDTH-1:0] addr_d;

  assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, mosi_s};
  assign mapped    = (addr_q <= ADDR_MAX_L);
  assign addr_d    = (addr_q == ADDR_MAX_L) ? '0 : addr_q + 1'b1;

  always_comb begin
    rd_byte = 8'h00;
    if (mapped) rd_byte = io_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else if (cs_fall) begin
      bit_cnt_q <= '0;
    end else if (sck_rise) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= rx_byte[6:0];
    end
  end

  // Strobes and bus drive default low every cycle so each is a single pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      autoinc_q <= 1'b0;
      wdata_q   <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= ~cs_n_s;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) state_q <= CMD;
        end
        CMD: begin
          miso_q <= 1'b0;
          if (cs_n_s)       state_q <= IDLE;
          else if (cs_fall) state_q <= CMD;
          else if (byte_done) begin
            addr_q    <= ADDRESS_WIDTH'(rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
            autoinc_q <= rx_byte[CMD_AUTOINC_BIT];
            if (rx_byte[CMD_RW_BIT]) begin
              state_q <= RD_FETCH;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= WR;
            end
          end
        end
        WR: begin
          miso_q <= 1'b0;
          if (cs_n_s)       state_q <= IDLE;
          else if (cs_fall) state_q <= CMD;
          else if (byte_done) begin
            wdata_q <= rx_byte;
            wr_en_q <= mapped;
            oe_q    <= mapped;
            state_q <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          miso_q <= 1'b0;
          if (autoinc_q) addr_q <= addr_d;
          if (cs_n_s)       state_q <= IDLE;
          else if (cs_fall) state_q <= CMD;
          else              state_q <= WR;
        end
        RD_FETCH: begin
          tx_q   <= rd_byte;
          miso_q <= rd_byte[7] & ~cs_n_s;
          if (autoinc_q) addr_q <= addr_d;
          if (cs_n_s)       state_q <= IDLE;
          else if (cs_fall) state_q <= CMD;
          else              state_q <= RD;
        end
        RD: begin
          if (cs_n_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end else if (cs_fall) begin
            state_q <= CMD;
            miso_q  <= 1'b0;
          end else if (byte_done) begin
            state_q <= RD_FETCH;
            rd_en_q <= 1'b1;
          end else if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_q   <= {tx_q[6:0], 1'b0};
            miso_q <= tx_q[6];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_data    = oe_q ? wdata_q : 'z;
  assign o_spi_miso = miso_q;
  assign o_write_en = wr_en_q;
  assign o_read_en  = rd_en_q;
  assign o_address  = addr_q;
  assign o_busy     = busy_q;

endmodule
